ysyx_23060111_ctrl: RTL and testbench
=====================================

# ysyx_23060111_ctrl

Multi-cycle sequencer for the core datapath: owns the PC, fetches each instruction through a valid/ready instruction-memory port, holds it stable for the combinational decode/execute path, and issues a load/store memory request when needed. It gates the register-file write and commits `dnpc` once per instruction. It sits between the instruction/data memory interfaces and the IDU/EXU/regfile, and also provides halt (ebreak) and a bus-timeout error.

## Interface
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.
- `TIMEOUT`, 255: maximum cycles spent in any wait state before entering ERR; legal range 1..65535.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_addr`  out  32  fetch address; equals `pc`.
- `ifu_req_ready`  in  1  fetch request accepted.
- `ifu_rsp_valid`  in  1  fetch data valid.
- `ifu_rsp_inst`  in  32  fetched instruction.
- `ifu_rsp_ready`  out  1  controller ready for fetch data.
- `inst`  out  32  latched instruction to IDU/EXU.
- `pc`  out  32  current PC to EXU.
- `exu_dnpc`  in  32  next PC computed by EXU.
- `lsu_req_valid`  out  1  load/store request valid.
- `lsu_req_ready`  in  1  load/store request accepted.
- `lsu_rsp_valid`  in  1  load data / store ack valid.
- `rf_wen`  out  1  one-cycle register-file write strobe.
- `halt`  out  1  sticky, ebreak executed.
- `err`  out  1  sticky, timeout or misaligned PC.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
- IDLE: entered on reset only; moves to FETCH_REQ on the next edge.
- FETCH_REQ: `ifu_req_valid`=1. Moves to FETCH_WAIT when `ifu_req_ready`=1.
- FETCH_WAIT: `ifu_rsp_ready`=1. On `ifu_rsp_valid`, latch `inst`, then move to EXEC. A response in the same cycle as request acceptance is ignored.
- EXEC: `inst`/`pc` stable.
  - `inst`==32'h0010_0073 (ebreak) -> HALT.
  - opcode 0000011 or 0100011 -> MEM_REQ.
  - otherwise -> WB.
- MEM_REQ/MEM_WAIT: same handshake as fetch using `lsu_req_valid`/`lsu_req_ready`/`lsu_rsp_valid`; then -> WB.
- WB:
  - `rf_wen`=1 unless opcode is 0100011 (store) or 1100011 (branch), or rd (`inst[11:7]`)==0.
  - `pc`<=`exu_dnpc`, then -> FETCH_REQ.
  - If `exu_dnpc[1:0]`!=0: `pc` is not updated, `rf_wen`=0, go to ERR.
- HALT/ERR: terminal. All request outputs are 0. `halt`/`err` stay 1 until reset.
- Watchdog: counts cycles in FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT. It clears on every state change. When it reaches `TIMEOUT` -> ERR.

## Timing
- Reset values: `pc`=RESET_PC, `inst`=0, and every 1-bit output = 0. These hold for the whole time `rst_n` is low.
- Reset asserted mid-instruction aborts immediately with no commit. An outstanding bus transaction is dropped.
- Minimum latency per non-memory instruction is 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB). Minimum for load/store is 6.
- Valid-signal rules:
  - `*_req_valid` is held, with address stable, until ready is sampled high.
  - It never deasserts without a handshake, except on reset or timeout.
- `rf_wen` is high for exactly one cycle per committing instruction, in WB.
- `ifu_req_addr` is always equal to `pc` (combinational).

## Configuration
- `YSYX_23060111_PERF_EN` defined: adds outputs `cycle_cnt` (64-bit) and `instret_cnt` (64-bit). Both reset to 0.
  - `cycle_cnt` increments every cycle outside HALT/ERR.
  - `instret_cnt` increments on every successful WB. Both wrap modulo 2^64.
- Not defined: the ports and counters are absent, with zero logic cost.

## Structure
- Shared package `ysyx_23060111_pkg`: state encoding, opcode constants (LOAD, STORE, BRANCH), and the EBREAK encoding.
- One sub-module `ysyx_23060111_ctrl_wdog`: 16-bit wait counter with `clr`/`en` inputs and a `expired` output compared against `TIMEOUT`.

## Test plan
- Reset release with ready held high and response one cycle later. Instruction addi (32'h0010_0093) with `exu_dnpc`=8000_0004 -> `ifu_req_addr`=8000_0000 first, one-cycle `rf_wen` in cycle 4, `pc`=8000_0004.
- Load (32'h0000_2103) with `lsu_req_ready` delayed 3 cycles -> `lsu_req_valid` held 4 cycles, `rf_wen` once after `lsu_rsp_valid`. Store (32'h0020_2023) -> `rf_wen` never asserts.
- ebreak fetched -> `halt`=1, no further `ifu_req_valid`; `pc` unchanged.
- `ifu_req_ready` stuck 0 with `TIMEOUT`=10 -> `err`=1 exactly 10 cycles after FETCH_REQ entry.
- `exu_dnpc`=8000_0002 on jalr -> `err`=1, `rf_wen`=0, `pc` keeps the old value.
- `rst_n` pulled low during MEM_WAIT -> outputs return to reset values immediately. With `YSYX_23060111_PERF_EN` defined, `instret_cnt`=0 after release.

Source files
------------

// File: rtl/ysyx_23060111_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060111_pkg
//  Purpose  : Shared definitions for the multi-cycle core controller:
//             sequencer state encoding, RV32 opcode constants used for
//             decode inside the controller, the EBREAK encoding and small
//             decode helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_23060111_pkg;

    // Sequencer state type and encoding. Values are fixed so that waveforms
    // and any external debug tap see a stable numbering.
    typedef logic [3:0] state_t;

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_FETCH_REQ  = 4'd1;
    localparam logic [3:0] c_ST_FETCH_WAIT = 4'd2;
    localparam logic [3:0] c_ST_EXEC       = 4'd3;
    localparam logic [3:0] c_ST_MEM_REQ    = 4'd4;
    localparam logic [3:0] c_ST_MEM_WAIT   = 4'd5;
    localparam logic [3:0] c_ST_WB         = 4'd6;
    localparam logic [3:0] c_ST_HALT       = 4'd7;
    localparam logic [3:0] c_ST_ERR        = 4'd8;

    // Major opcodes the controller must recognise.
    localparam logic [6:0] c_OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] c_OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b110_0011;

    // Full-word encoding of ebreak.
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;

    // Loads and stores need a data-memory transaction before write-back.
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == c_OPC_LOAD) || (opcode == c_OPC_STORE);
    endfunction

    // Stores and branches have no destination register; rd == x0 is
    // architecturally discarded, so no write strobe is raised either.
    function automatic logic writes_rd(input logic [6:0] opcode,
                                       input logic [4:0] rd);
        return (opcode != c_OPC_STORE) && (opcode != c_OPC_BRANCH) &&
               (rd != 5'd0);
    endfunction

endpackage : ysyx_23060111_pkg
`default_nettype wire

// File: rtl/ysyx_23060111_ctrl_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060111_ctrl_wdog
//  Purpose  : Bus-wait watchdog. A 16-bit counter that tracks how many
//             consecutive cycles the sequencer has spent in one wait state.
//             'expired' rises during the TIMEOUT-th such cycle so that the
//             sequencer leaves for ERR on the edge that completes it.
//  Ports    : clk      - system clock
//             rst_n    - asynchronous active-low reset
//             clr      - restart count (state change or not waiting)
//             en       - currently in a wait state
//             expired  - wait budget exhausted in this cycle
//  Params   : TIMEOUT  - cycles allowed per wait state, 1..65535
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_23060111_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // cnt_q holds the number of already completed cycles in the current
    // wait state, so the cycle with cnt_q == TIMEOUT-1 is the last one.
    localparam logic [15:0] c_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == c_LAST);

endmodule : ysyx_23060111_ctrl_wdog
`default_nettype wire

// File: rtl/ysyx_23060111_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060111_ctrl
//  Purpose  : Multi-cycle sequencer for the core datapath. Owns the PC,
//             fetches one instruction at a time over a valid/ready port,
//             holds it stable for the combinational IDU/EXU, issues a
//             load/store request when needed, strobes the register-file
//             write and commits dnpc once per instruction. Provides sticky
//             halt (ebreak) and err (bus timeout / misaligned next PC).
//  Ports    : clk, rst_n                      clock, async active-low reset
//             ifu_req_valid/addr/ready        fetch request channel
//             ifu_rsp_valid/inst/ready        fetch response channel
//             inst, pc                        latched instruction, current PC
//             exu_dnpc                        next PC from EXU
//             lsu_req_valid/ready, lsu_rsp_valid  data-memory handshake
//             rf_wen                          one-cycle write-back strobe
//             halt, err                       sticky terminal status
//             cycle_cnt, instret_cnt          (YSYX_23060111_PERF_EN only)
//  Params   : RESET_PC  PC loaded on reset
//             TIMEOUT   max cycles in any wait state (1..65535)
//  Config   : `define YSYX_23060111_PERF_EN to add 64-bit cycle and
//             retired-instruction counters.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_23060111_ctrl
    import ysyx_23060111_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        ifu_rsp_ready,
    // decode / execute
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] exu_dnpc,
    // load / store
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    // write-back and status
    output logic        rf_wen,
    output logic        halt,
    output logic        err
`ifdef YSYX_23060111_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        halt_q;
    logic        err_q;

    logic        w_wait_state;
    logic        w_wdog_clr;
    logic        w_expired;
    logic        w_dnpc_aligned;
    logic        w_is_ebreak;
    logic        w_is_mem;
    logic        w_writes_rd;
    logic        w_commit;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    assign w_is_ebreak    = (inst_q == c_INST_EBREAK);
    assign w_is_mem       = is_mem_op(inst_q[6:0]);
    assign w_writes_rd    = writes_rd(inst_q[6:0], inst_q[11:7]);
    assign w_dnpc_aligned = (exu_dnpc[1:0] == 2'b00);

    // An instruction commits only from WB with a word-aligned next PC;
    // a misaligned target aborts to ERR with nothing architecturally updated.
    assign w_commit = (state_q == c_ST_WB) && w_dnpc_aligned;

    // ------------------------------------------------------------------
    // Watchdog: counts only while waiting on a bus handshake and restarts
    // whenever the state changes, so each wait state gets its own budget.
    // ------------------------------------------------------------------
    assign w_wait_state = (state_q == c_ST_FETCH_REQ)  ||
                          (state_q == c_ST_FETCH_WAIT) ||
                          (state_q == c_ST_MEM_REQ)    ||
                          (state_q == c_ST_MEM_WAIT);
    assign w_wdog_clr   = (state_d != state_q) || !w_wait_state;

    ysyx_23060111_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_wdog_clr),
        .en      (w_wait_state),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // Next-state logic. A handshake completing in the same cycle as the
    // watchdog expiry takes priority, so a transfer is never lost.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                state_d = c_ST_FETCH_REQ;
            end
            c_ST_FETCH_REQ: begin
                if (ifu_req_ready) begin
                    state_d = c_ST_FETCH_WAIT;
                end else if (w_expired) begin
                    state_d = c_ST_ERR;
                end
            end
            c_ST_FETCH_WAIT: begin
                // The response is only looked at from here, so one that
                // arrives alongside request acceptance is ignored.
                if (ifu_rsp_valid) begin
                    state_d = c_ST_EXEC;
                end else if (w_expired) begin
                    state_d = c_ST_ERR;
                end
            end
            c_ST_EXEC: begin
                if (w_is_ebreak) begin
                    state_d = c_ST_HALT;
                end else if (w_is_mem) begin
                    state_d = c_ST_MEM_REQ;
                end else begin
                    state_d = c_ST_WB;
                end
            end
            c_ST_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = c_ST_MEM_WAIT;
                end else if (w_expired) begin
                    state_d = c_ST_ERR;
                end
            end
            c_ST_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = c_ST_WB;
                end else if (w_expired) begin
                    state_d = c_ST_ERR;
                end
            end
            c_ST_WB: begin
                state_d = w_dnpc_aligned ? c_ST_FETCH_REQ : c_ST_ERR;
            end
            c_ST_HALT: begin
                state_d = c_ST_HALT;
            end
            c_ST_ERR: begin
                state_d = c_ST_ERR;
            end
            default: begin
                // Unreachable encodings are treated as a fault.
                state_d = c_ST_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, PC, instruction latch and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == c_ST_FETCH_WAIT) && ifu_rsp_valid) begin
                inst_q <= ifu_rsp_inst;
            end
            if (w_commit) begin
                pc_q <= exu_dnpc;
            end
            if (state_d == c_ST_HALT) begin
                halt_q <= 1'b1;
            end
            if (state_d == c_ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. All request valids are pure state decodes, which keeps
    // them held until the handshake and forces them low in HALT/ERR.
    // ------------------------------------------------------------------
    assign ifu_req_valid = (state_q == c_ST_FETCH_REQ);
    assign ifu_req_addr  = pc_q;
    assign ifu_rsp_ready = (state_q == c_ST_FETCH_WAIT);
    assign lsu_req_valid = (state_q == c_ST_MEM_REQ);
    assign rf_wen        = w_commit && w_writes_rd;
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign halt          = halt_q;
    assign err           = err_q;

`ifdef YSYX_23060111_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, both free-running modulo 2^64.
    // ------------------------------------------------------------------
    logic [63:0] cycle_cnt_q;
    logic [63:0] instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 64'd0;
            instret_cnt_q <= 64'd0;
        end else begin
            if ((state_q != c_ST_HALT) && (state_q != c_ST_ERR)) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end
            if (w_commit) begin
                instret_cnt_q <= instret_cnt_q + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule : ysyx_23060111_ctrl
`default_nettype wire

// File: tb/tb_ysyx_23060111_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060111_ctrl
//  Purpose  : Self-checking bench for ysyx_23060111_ctrl. A table of
//             instructions with hand-computed write-back and next-PC
//             expectations, plus directed sequences for stalls, timeout,
//             misaligned target, ebreak and mid-instruction reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_23060111_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam int unsigned c_TIMEOUT  = 10;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        ifu_rsp_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] exu_dnpc;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        rf_wen;
    logic        halt;
    logic        err;
`ifdef YSYX_23060111_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    ysyx_23060111_ctrl #(
        .RESET_PC (c_RESET_PC),
        .TIMEOUT  (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .ifu_rsp_ready (ifu_rsp_ready),
        .inst          (inst),
        .pc            (pc),
        .exu_dnpc      (exu_dnpc),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_wen        (rf_wen),
        .halt          (halt),
        .err           (err)
`ifdef YSYX_23060111_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] dnpc;
        logic        is_mem;
        logic        exp_wen;
    } vec_t;

    vec_t        vecs [7];
    int          total;
    int          bad;
    logic [31:0] exp_pc;
    int          exp_instret;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'd0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        exu_dnpc      = 32'd0;
        tick();
        tick();
        chk("rst_pc", pc, c_RESET_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_outs", {ifu_req_valid, ifu_rsp_ready, lsu_req_valid,
                         rf_wen, halt, err}, 6'd0);
        rst_n = 1'b1;
        tick();                       // IDLE -> FETCH_REQ
        exp_pc      = c_RESET_PC;
        exp_instret = 0;
    endtask

    // From FETCH_REQ: accept the request, return 'op' the next cycle,
    // leave the DUT in EXEC with dnpc presented.
    task automatic fetch(input logic [31:0] op, input logic [31:0] dnpc);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = op;
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'd0;
        exu_dnpc      = dnpc;
    endtask

    task automatic run_vec(input vec_t v);
        chk("fetch_valid", ifu_req_valid, 1'b1);
        chk("fetch_addr", ifu_req_addr, exp_pc);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = v.op;
        chk("rsp_ready", ifu_rsp_ready, 1'b1);
        chk("req_dropped", ifu_req_valid, 1'b0);
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'd0;
        exu_dnpc      = v.dnpc;
        chk("exec_inst", inst, v.op);
        chk("exec_wen", rf_wen, 1'b0);
        tick();
        if (v.is_mem) begin
            chk("lsu_valid", lsu_req_valid, 1'b1);
            lsu_req_ready = 1'b1;
            tick();
            lsu_req_ready = 1'b0;
            lsu_rsp_valid = 1'b1;
            chk("lsu_dropped", lsu_req_valid, 1'b0);
            tick();
            lsu_rsp_valid = 1'b0;
        end else begin
            chk("no_lsu", lsu_req_valid, 1'b0);
        end
        chk("wb_wen", rf_wen, v.exp_wen);
        tick();
        exp_pc = v.dnpc;
        exp_instret++;
        chk("commit_pc", pc, exp_pc);
        chk("after_wb_wen", rf_wen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        //           op             dnpc           mem   wen
        vecs[0] = '{32'h0010_0093, 32'h8000_0004, 1'b0, 1'b1}; // addi x1
        vecs[1] = '{32'h0000_0063, 32'h8000_0010, 1'b0, 1'b0}; // beq
        vecs[2] = '{32'h0000_0033, 32'h8000_0014, 1'b0, 1'b0}; // add x0
        vecs[3] = '{32'h0000_02b7, 32'h8000_0018, 1'b0, 1'b1}; // lui x5
        vecs[4] = '{32'h0000_2103, 32'h8000_001c, 1'b1, 1'b1}; // lw x2
        vecs[5] = '{32'h0020_2023, 32'h8000_0020, 1'b1, 1'b0}; // sw
        vecs[6] = '{32'h0000_00ef, 32'h8000_0100, 1'b0, 1'b1}; // jal x1

        do_reset();
`ifdef YSYX_23060111_PERF_EN
        chk("cycle_after_release", cycle_cnt, 64'd1);
`endif
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
`ifdef YSYX_23060111_PERF_EN
        chk("instret_table", instret_cnt, 64'(exp_instret));
`endif

        // ---- load with lsu_req_ready held off for 3 cycles; a fetch
        //      response coinciding with request acceptance is ignored ----
        chk("ld_fetch_addr", ifu_req_addr, 32'h8000_0100);
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hDEAD_BEEF;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_inst  = 32'h0000_2103;
        tick();
        ifu_rsp_valid = 1'b0;
        exu_dnpc      = 32'h8000_0104;
        chk("ld_inst_not_early", inst, 32'h0000_2103);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("ld_valid_held", lsu_req_valid, 1'b1);
            tick();
        end
        chk("ld_valid_4th", lsu_req_valid, 1'b1);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        chk("ld_valid_released", lsu_req_valid, 1'b0);
        chk("ld_wait_wen", rf_wen, 1'b0);
        tick();
        lsu_rsp_valid = 1'b1;
        chk("ld_wait2_wen", rf_wen, 1'b0);
        tick();
        lsu_rsp_valid = 1'b0;
        chk("ld_wb_wen", rf_wen, 1'b1);
        tick();
        exp_instret++;
        chk("ld_after_wen", rf_wen, 1'b0);
        chk("ld_pc", pc, 32'h8000_0104);

        // ---- jalr to a misaligned target ----
        fetch(32'h0000_00e7, 32'h8000_0002);
        tick();
        chk("mis_wb_wen", rf_wen, 1'b0);
        tick();
        chk("mis_err", err, 1'b1);
        chk("mis_pc_kept", pc, 32'h8000_0104);
        tick();
        chk("mis_no_fetch", ifu_req_valid, 1'b0);
        chk("mis_err_sticky", err, 1'b1);
`ifdef YSYX_23060111_PERF_EN
        chk("mis_instret", instret_cnt, 64'(exp_instret));
`endif

        // ---- fetch never accepted: err exactly c_TIMEOUT cycles after
        //      entering FETCH_REQ ----
        do_reset();
        for (int k = 1; k <= int'(c_TIMEOUT); k++) begin
            chk("to_valid_held", ifu_req_valid, 1'b1);
            chk("to_err_early", err, 1'b0);
            tick();
        end
        chk("to_err", err, 1'b1);
        chk("to_valid_off", ifu_req_valid, 1'b0);

        // ---- ebreak ----
        do_reset();
        fetch(32'h0010_0073, 32'h8000_0004);
        chk("eb_exec_halt", halt, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("eb_halt", halt, 1'b1);
            chk("eb_no_fetch", ifu_req_valid, 1'b0);
            chk("eb_pc", pc, c_RESET_PC);
            tick();
        end
        chk("eb_no_err", err, 1'b0);

        // ---- reset asserted during MEM_WAIT ----
        do_reset();
        run_vec(vecs[0]);
        fetch(32'h0000_2103, 32'h8000_0008);
        tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        chk("rw_pc_before", pc, 32'h8000_0004);
        rst_n = 1'b0;
        #1;
        chk("rw_pc_async", pc, c_RESET_PC);
        chk("rw_inst_async", inst, 32'd0);
        chk("rw_outs_async", {ifu_req_valid, ifu_rsp_ready, lsu_req_valid,
                              rf_wen, halt, err}, 6'd0);
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        chk("rw_wen_in_rst", rf_wen, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rw_refetch", ifu_req_valid, 1'b1);
        chk("rw_refetch_addr", ifu_req_addr, c_RESET_PC);
`ifdef YSYX_23060111_PERF_EN
        chk("rw_instret", instret_cnt, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ysyx_23060111_ctrl
`default_nettype wire
